// File: rtl/md_unit_if.sv
// Handshake and data bundle between the EX stage and the multiply/divide unit.
// The master drives the operation request; the slave returns status and HI/LO.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Results are computed combinationally from latched operands and committed after N busy cycles.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic         clk,
  input logic         rst,
  md_unit_if.slave    bus
);
  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_hi, w_hi_d;
  logic [WIDTH-1:0] r_lo, w_lo_d;
  logic             r_done, w_done_d;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic             w_latch;

  // r_op[1] selects divide, r_op[0] selects unsigned.
  logic               w_sgn, w_a_neg, w_b_neg;
  logic [2*WIDTH-1:0] w_prod_s, w_prod_u;
  logic [WIDTH-1:0]   w_div_a, w_div_b, w_quo, w_rem, w_quo_f, w_rem_f;

  always_comb begin
    w_sgn    = ~r_op[0];
    w_a_neg  = w_sgn & r_a[WIDTH-1];
    w_b_neg  = w_sgn & r_b[WIDTH-1];
    w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
    w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
    w_div_a  = w_a_neg ? (~r_a + WIDTH'(1)) : r_a;
    // Substitute 1 for a zero divisor so the divider never sees X; the result is discarded.
    if (r_b == '0) begin
      w_div_b = WIDTH'(1);
    end else begin
      w_div_b = w_b_neg ? (~r_b + WIDTH'(1)) : r_b;
    end
    w_quo   = w_div_a / w_div_b;
    w_rem   = w_div_a % w_div_b;
    w_quo_f = (w_a_neg ^ w_b_neg) ? (~w_quo + WIDTH'(1)) : w_quo;
    w_rem_f = w_a_neg ? (~w_rem + WIDTH'(1)) : w_rem;
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_hi_d    = r_hi;
    w_lo_d    = r_lo;
    w_done_d  = 1'b0;
    w_latch   = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          if (bus.op <= 3'd3) begin
            w_latch   = 1'b1;
            w_state_d = StRun;
            w_cnt_d   = bus.op[1] ? DivLoad : MultLoad;
          end else if (bus.op == 3'd4) begin
            w_hi_d = bus.a;
          end else if (bus.op == 3'd5) begin
            w_lo_d = bus.a;
          end
        end
      end
      StRun: begin
        if (bus.cancel) begin
          w_state_d = StIdle;
        end else if (r_cnt == '0) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
          if (!r_op[1]) begin
            {w_hi_d, w_lo_d} = r_op[0] ? w_prod_u : w_prod_s;
          end else if (r_b != '0) begin
            w_hi_d = w_rem_f;
            w_lo_d = w_quo_f;
          end
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_hi    <= w_hi_d;
      r_lo    <= w_lo_d;
      r_done  <= w_done_d;
      if (w_latch) begin
        r_op <= bus.op[1:0];
        r_a  <= bus.a;
        r_b  <= bus.b;
      end
    end
  end

  assign bus.busy = (r_state == StRun);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: vector table for arithmetic and latency, plus
// hand sequences for MT ops, ignored starts, cancel, async reset and alternate latencies.
module tb_md_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(32)) bus ();
  md_unit_if #(.WIDTH(32)) bus2 ();

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(33)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one op on the primary DUT, scramble operands afterwards, count busy cycles.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n_busy, output logic done_seen, output logic done_after);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678;
    n_busy = 0;
    while (bus.busy && n_busy < 200) begin
      n_busy++;
      @(negedge clk);
    end
    done_seen = bus.done;
    @(negedge clk);
    done_after = bus.done;
  endtask

  task automatic do_op2(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n_busy, output logic done_seen);
    bus2.start = 1'b1; bus2.op = op; bus2.a = a; bus2.b = b;
    @(negedge clk);
    bus2.start = 1'b0; bus2.a = 32'hDEAD_BEEF; bus2.b = 32'h1234_5678;
    n_busy = 0;
    while (bus2.busy && n_busy < 200) begin
      n_busy++;
      @(negedge clk);
    end
    done_seen = bus2.done;
  endtask

  // Start DIV 100/3 and raise cancel during busy cycle number 'at'.
  task automatic do_cancel(input int at, output int n_busy, output logic done_any);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd3;
    n_busy   = 0;
    done_any = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      done_any  = done_any | bus.done;
      if (!bus.busy) break;
      n_busy++;
      bus.cancel = (n_busy == at);
    end
    bus.cancel = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      done_any = done_any | bus.done;
    end
  endtask

  initial begin
    int   nb;
    logic ds, da;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFD, 32'd7,        5,  32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,        5,  32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
    vecs[4]  = '{3'd3, 32'd5,         32'd0,        10, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{3'd3, 32'd100,       32'd7,        10, 32'h0000_0002, 32'h0000_000E};
    vecs[6]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000};
    vecs[7]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{3'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 10, 32'hFFFF_FFFE, 32'h0000_0002};
    vecs[9]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[10] = '{3'd2, 32'hFFFF_FFFF, 32'd0,        10, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[11] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 5, 32'h0000_0001, 32'h0000_0000};

    bus.start = 1'b0;  bus.op = 3'd7;  bus.a = '0;  bus.b = '0;  bus.cancel = 1'b0;
    bus2.start = 1'b0; bus2.op = 3'd7; bus2.a = '0; bus2.b = '0; bus2.cancel = 1'b0;

    // Reset state
    #12;
    check("rst_busy_done", 64'({bus.busy, bus.done}), 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // MTHI / MTLO in idle
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    check("mthi_hi", 64'(bus.hi), 64'h1234);
    check("mthi_busy_done", 64'({bus.busy, bus.done}), 64'd0);
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h5678;
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo_hilo", {bus.hi, bus.lo}, {32'h1234, 32'h5678});
    check("mtlo_busy_done", 64'({bus.busy, bus.done}), 64'd0);

    // Arithmetic / latency table
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, nb, ds, da);
      check($sformatf("v%0d_busy", i), 64'(nb), 64'(vecs[i].busy));
      check($sformatf("v%0d_done", i), 64'(ds), 64'd1);
      check($sformatf("v%0d_done_drop", i), 64'(da), 64'd0);
      check($sformatf("v%0d_hi", i), 64'(bus.hi), 64'(vecs[i].hi));
      check($sformatf("v%0d_lo", i), 64'(bus.lo), 64'(vecs[i].lo));
    end

    // MTLO and MULT issued while busy are ignored
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd4;
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      nb++;
      bus.start = (nb == 2) || (nb == 3);
      bus.op    = (nb == 2) ? 3'd5 : 3'd0;
      bus.a     = (nb == 2) ? 32'hFFFF : 32'd9;
      bus.b     = 32'd9;
    end
    bus.start = 1'b0;
    check("ign_busy", 64'(nb), 64'd5);
    check("ign_done", 64'(bus.done), 64'd1);
    check("ign_hilo", {bus.hi, bus.lo}, {32'h0, 32'hC});
    @(negedge clk);
    check("ign_no_restart", 64'({bus.busy, bus.done}), 64'd0);

    // Cancel on busy cycle 4 and on the final busy cycle
    do_cancel(4, nb, ds);
    check("cancel4_busy", 64'(nb), 64'd4);
    check("cancel4_no_done", 64'(ds), 64'd0);
    check("cancel4_hilo", {bus.hi, bus.lo}, {32'h0, 32'hC});
    do_cancel(10, nb, ds);
    check("cancel10_busy", 64'(nb), 64'd10);
    check("cancel10_no_done", 64'(ds), 64'd0);
    check("cancel10_hilo", {bus.hi, bus.lo}, {32'h0, 32'hC});

    // Async reset mid-MULT with nonzero HI/LO
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hABCD;
    @(negedge clk);
    bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'd8;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy_done", 64'({bus.busy, bus.done}), 64'd0);
    check("async_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Alternate latencies: MULT_CYCLES=1, DIV_CYCLES=33
    do_op2(3'd0, 32'd6, 32'd7, nb, ds);
    check("p1_mult_busy", 64'(nb), 64'd1);
    check("p1_mult_done", 64'(ds), 64'd1);
    check("p1_mult_hilo", {bus2.hi, bus2.lo}, {32'h0, 32'd42});
    @(negedge clk);
    do_op2(3'd3, 32'd100, 32'd7, nb, ds);
    check("p33_div_busy", 64'(nb), 64'd33);
    check("p33_div_done", 64'(ds), 64'd1);
    check("p33_div_hilo", {bus2.hi, bus2.lo}, {32'd2, 32'd14});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
